// File: rtl/alu_pkg.sv
// Shared definitions for the MicroUAZ ALU: opcode encodings, flag bit positions
// and a helper that assembles the status vector.
package alu_pkg;

    localparam int ALU_WIDTH = 8;
    localparam int FLAG_W    = 3;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_ROL   = 4'b1000;
    localparam logic [3:0] OP_ROR   = 4'b1001;
    localparam logic [3:0] OP_INC   = 4'b1010;
    localparam logic [3:0] OP_DEC   = 4'b1011;
    localparam logic [3:0] OP_NEG   = 4'b1100;
    localparam logic [3:0] OP_PASSA = 4'b1101;
    localparam logic [3:0] OP_PASSB = 4'b1110;
    localparam logic [3:0] OP_CMP   = 4'b1111;

    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    function automatic flags_t pack_flags(input logic n, input logic z, input logic c);
        flags_t f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational core of the ALU: next result, next flags, and whether R0 should
// take the new result (everything except CMP).
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] result,
    output flags_t           flags,
    output logic             update_r0
);

    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] res;
    logic             carry;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned; that is what keeps latches out.
    always_comb begin
        wide      = '0;
        res       = '0;
        carry     = 1'b0;
        update_r0 = 1'b1;
        case (sel)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            // The extra top bit of an unsigned subtraction is exactly the borrow.
            OP_SUB, OP_CMP: begin
                wide      = {1'b0, a} - {1'b0, b};
                res       = wide[WIDTH-1:0];
                carry     = wide[WIDTH];
                update_r0 = (sel != OP_CMP);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL: begin
                res   = {a[WIDTH-2:0], 1'b0};
                carry = a[WIDTH-1];
            end
            OP_SHR: begin
                res   = {1'b0, a[WIDTH-1:1]};
                carry = a[0];
            end
            OP_ROL: begin
                res   = {a[WIDTH-2:0], a[WIDTH-1]};
                carry = a[WIDTH-1];
            end
            OP_ROR: begin
                res   = {a[0], a[WIDTH-1:1]};
                carry = a[0];
            end
            OP_INC: begin
                wide  = {1'b0, a} + (WIDTH+1)'(1);
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_DEC: begin
                wide  = {1'b0, a} - (WIDTH+1)'(1);
                res   = wide[WIDTH-1:0];
                carry = wide[WIDTH];
            end
            OP_NEG: begin
                res   = '0 - a;
                carry = |a;
            end
            OP_PASSA: res = a;
            OP_PASSB: res = b;
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

    assign result = res;
    assign flags  = pack_flags(res[WIDTH-1], (res == '0), carry);

endmodule

// File: rtl/alu.sv
// Registered 8-bit ALU: result and flags captured on every rising clk edge,
// cleared asynchronously by rst_n.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] RY,
    input  logic [WIDTH-1:0] RX,
    input  logic [3:0]       Sel_ALU,
    output logic [WIDTH-1:0] R0,
    output logic [2:0]       Flags
);

    logic [WIDTH-1:0] comb_result;
    flags_t           comb_flags;
    logic             comb_update;

    logic [WIDTH-1:0] r0_d, r0_q;
    flags_t           flags_d, flags_q;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a         (RY),
        .b         (RX),
        .sel       (Sel_ALU),
        .result    (comb_result),
        .flags     (comb_flags),
        .update_r0 (comb_update)
    );

    // CMP refreshes only the flags; R0 recirculates its held value.
    always_comb begin
        r0_d    = comb_update ? comb_result : r0_q;
        flags_d = comb_flags;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_q    <= '0;
            flags_q <= '0;
        end else begin
            r0_q    <= r0_d;
            flags_q <= flags_d;
        end
    end

    assign R0    = r0_q;
    assign Flags = flags_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] RY;
    logic [7:0] RX;
    logic [3:0] Sel_ALU;
    logic [7:0] R0;
    logic [2:0] Flags;

    int n_checks;
    int n_errors;

    alu #(
        .WIDTH (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RY      (RY),
        .RX      (RX),
        .Sel_ALU (Sel_ALU),
        .R0      (R0),
        .Flags   (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive on the falling edge, capture on the next rising edge, sample 1 time unit later.
    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp_r, input logic [2:0] exp_f);
        @(negedge clk);
        Sel_ALU = op;
        RY      = a;
        RX      = b;
        @(posedge clk);
        #1;
        check({tag, " R0"}, 32'(R0), 32'(exp_r));
        check({tag, " Flags"}, 32'(Flags), 32'(exp_f));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        Sel_ALU  = OP_ADD;
        RY       = 8'hFF;
        RX       = 8'h01;

        #2;
        check("reset before edge R0", 32'(R0), 32'h00);
        check("reset before edge Flags", 32'(Flags), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset held R0", 32'(R0), 32'h00);
        check("reset held Flags", 32'(Flags), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run("ADD ff+01",   OP_ADD,   8'hFF, 8'h01, 8'h00, 3'b011);
        run("ADD 2+1",     OP_ADD,   8'h02, 8'h01, 8'h03, 3'b000);
        run("ADD 80+80",   OP_ADD,   8'h80, 8'h80, 8'h00, 3'b011);
        run("SUB 4-4",     OP_SUB,   8'h04, 8'h04, 8'h00, 3'b010);
        run("SUB 4-5",     OP_SUB,   8'h04, 8'h05, 8'hFF, 3'b101);
        run("SUB 4-3",     OP_SUB,   8'h04, 8'h03, 8'h01, 3'b000);
        run("SUB 10-5",    OP_SUB,   8'h0A, 8'h05, 8'h05, 3'b000);
        run("CMP 4,5",     OP_CMP,   8'h04, 8'h05, 8'h05, 3'b101);
        run("CMP 9,9",     OP_CMP,   8'h09, 8'h09, 8'h05, 3'b010);
        run("SHL 81",      OP_SHL,   8'h81, 8'h00, 8'h02, 3'b001);
        run("SHR 01",      OP_SHR,   8'h01, 8'h00, 8'h00, 3'b011);
        run("ROL 81",      OP_ROL,   8'h81, 8'h00, 8'h03, 3'b001);
        run("ROR 01",      OP_ROR,   8'h01, 8'h00, 8'h80, 3'b101);
        run("AND f0,0f",   OP_AND,   8'hF0, 8'h0F, 8'h00, 3'b010);
        run("OR 50,0a",    OP_OR,    8'h50, 8'h0A, 8'h5A, 3'b000);
        run("XOR ff,0f",   OP_XOR,   8'hFF, 8'h0F, 8'hF0, 3'b100);
        run("NOT 0f",      OP_NOT,   8'h0F, 8'h00, 8'hF0, 3'b100);
        run("INC ff",      OP_INC,   8'hFF, 8'h00, 8'h00, 3'b011);
        run("DEC 00",      OP_DEC,   8'h00, 8'h00, 8'hFF, 3'b101);
        run("NEG 01",      OP_NEG,   8'h01, 8'h00, 8'hFF, 3'b101);
        run("NEG 00",      OP_NEG,   8'h00, 8'h00, 8'h00, 3'b010);
        run("PASSA 80",    OP_PASSA, 8'h80, 8'h33, 8'h80, 3'b100);
        run("PASSB 00",    OP_PASSB, 8'h7F, 8'h00, 8'h00, 3'b010);
        run("SUB 4-5 pre", OP_SUB,   8'h04, 8'h05, 8'hFF, 3'b101);

        // Asynchronous reset pulse between edges, with a non-zero result pending.
        #2;
        Sel_ALU = OP_ADD;
        RY      = 8'h12;
        RX      = 8'h34;
        rst_n   = 1'b0;
        #1;
        check("async reset R0", 32'(R0), 32'h00);
        check("async reset Flags", 32'(Flags), 32'h0);
        rst_n = 1'b1;
        #1;
        check("after release R0", 32'(R0), 32'h00);
        check("after release Flags", 32'(Flags), 32'h0);

        run("ADD after reset", OP_ADD, 8'h02, 8'h01, 8'h03, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
